// File: rtl/activ_pkg.sv
// -----------------------------------------------------------------------------
// activ_pkg
// Shared definitions for the activation backward-pass unit (activ_backprop)
// and its Q8.8 multiplier.
//   - state_t      : FSM state encoding (IDLE, MUL1, MUL2, DONE)
//   - Q_ONE        : 1.0 in Q8.8
//   - FRAC_BITS    : number of fractional bits in Q8.8
//   - ACT_RELU / ACT_SIGMOID : act_sel encodings
//   - LEAKY_SHIFT  : right shift giving the leaky-ReLU slope of 1/16
// No ports (package).
// -----------------------------------------------------------------------------
package activ_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL1 = 2'd1,
        ST_MUL2 = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int          FRAC_BITS   = 8;
    localparam logic [15:0] Q_ONE       = 16'h0100;
    localparam logic        ACT_RELU    = 1'b0;
    localparam logic        ACT_SIGMOID = 1'b1;
    localparam int          LEAKY_SHIFT = 4;

endpackage : activ_pkg

// File: rtl/activ_backprop_multiplier.sv
// -----------------------------------------------------------------------------
// Multiplier
// Signed Q8.8 multiplier shared by the activation backward-pass unit.
// AB = (A * B) >>> 8, truncated to BITS bits (no saturation; callers keep the
// operands in a range where the product cannot overflow).
// Ports:
//   A  : input  signed [BITS-1:0]  multiplicand, Q8.8
//   B  : input  signed [BITS-1:0]  multiplier,   Q8.8
//   AB : output signed [BITS-1:0]  product,      Q8.8
// -----------------------------------------------------------------------------
module Multiplier
    import activ_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic signed [BITS-1:0] A,
    input  logic signed [BITS-1:0] B,
    output logic signed [BITS-1:0] AB
);

    // Full-precision product; the wide LHS sign-extends both operands.
    logic signed [2*BITS-1:0] prod;

    assign prod = A * B;
    assign AB   = BITS'(prod >>> FRAC_BITS);

endmodule : Multiplier

// File: rtl/activ_backprop.sv
// -----------------------------------------------------------------------------
// activ_backprop
// Backward-pass activation gradient unit, Q8.8 fixed point.
// grad_out = grad_in * f'(.) for ReLU (act_sel=0) or Sigmoid (act_sel=1).
//   ReLU    : grad_in when x > 0, else 0 (1 cycle after accept).
//   Sigmoid : zc = clamp(z, 0, 1.0); d = zc*(1-zc); grad_out = grad_in*d
//             (3 cycles after accept, one shared Multiplier).
// Optional feature macro: ACTIV_BP_LEAKY_EN
//   defined   -> ReLU with non-positive x returns grad_in >>> 4.
//   undefined -> ReLU with non-positive x returns 0.
// Ports:
//   clk       : in   clock
//   rst_n     : in   synchronous active-low reset
//   in_valid  : in   operands valid
//   in_ready  : out  unit accepts operands (IDLE only)
//   act_sel   : in   0 = ReLU, 1 = Sigmoid
//   x         : in   pre-activation value (ReLU)
//   z         : in   forward sigmoid output (Sigmoid)
//   grad_in   : in   upstream gradient
//   out_valid : out  grad_out valid (held until out_ready)
//   out_ready : in   downstream accepts result
//   grad_out  : out  local gradient
//   busy      : out  unit not in IDLE
// -----------------------------------------------------------------------------
module activ_backprop
    import activ_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            act_sel,
    input  logic [BITS-1:0] x,
    input  logic [BITS-1:0] z,
    input  logic [BITS-1:0] grad_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] grad_out,
    output logic            busy
);

    state_t                 state_q;
    logic                   out_valid_q;
    logic signed [BITS-1:0] grad_out_q;

    logic signed [BITS-1:0] z_q;
    logic signed [BITS-1:0] grad_in_q;
    logic signed [BITS-1:0] d_q;

    logic signed [BITS-1:0] zc_d;
    logic signed [BITS-1:0] relu_d;
    logic signed [BITS-1:0] mul_a;
    logic signed [BITS-1:0] mul_b;
    logic signed [BITS-1:0] mul_ab;

    logic                   accept;

    // Clamp a forward sigmoid output into [0, 1.0] so d = zc*(1-zc) stays
    // within [0, 0x0040] and the second multiply cannot overflow.
    function automatic logic signed [BITS-1:0] sig_clamp(input logic signed [BITS-1:0] zin);
        logic signed [BITS-1:0] r;
        if (zin[BITS-1]) begin
            r = '0;
        end else if (zin > $signed(Q_ONE)) begin
            r = $signed(Q_ONE);
        end else begin
            r = zin;
        end
        return r;
    endfunction

    // ReLU derivative applied to the gradient; x == 0 counts as non-positive.
    function automatic logic signed [BITS-1:0] relu_grad(input logic signed [BITS-1:0] xin,
                                                         input logic signed [BITS-1:0] gin);
        logic signed [BITS-1:0] r;
        if (!xin[BITS-1] && (xin != '0)) begin
            r = gin;
        end else begin
`ifdef ACTIV_BP_LEAKY_EN
            r = gin >>> LEAKY_SHIFT;
`else
            r = '0;
`endif
        end
        return r;
    endfunction

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign grad_out  = grad_out_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        zc_d   = sig_clamp(z_q);
        relu_d = relu_grad($signed(x), $signed(grad_in));
    end

    // Operand mux for the shared multiplier: MUL1 forms zc*(1-zc),
    // MUL2 forms grad_in*d. Other states leave the operands unused.
    always_comb begin
        mul_a = grad_in_q;
        mul_b = d_q;
        if (state_q == ST_MUL1) begin
            mul_a = zc_d;
            mul_b = $signed(Q_ONE) - zc_d;
        end
    end

    Multiplier #(
        .BITS (BITS)
    ) u_mul (
        .A  (mul_a),
        .B  (mul_b),
        .AB (mul_ab)
    );

    // Stage p0: operand capture at accept; d captured after MUL1.
    always_ff @(posedge clk) begin
        if (accept) begin
            z_q       <= $signed(z);
            grad_in_q <= $signed(grad_in);
        end
        if (state_q == ST_MUL1) begin
            d_q <= mul_ab;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            grad_out_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (act_sel == ACT_RELU) begin
                            // ReLU needs no multiply: result is ready at the accept edge.
                            grad_out_q  <= relu_d;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            state_q <= ST_MUL1;
                        end
                    end
                end
                ST_MUL1: begin
                    state_q <= ST_MUL2;
                end
                ST_MUL2: begin
                    grad_out_q  <= mul_ab;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : activ_backprop

// File: tb/tb_activ_backprop.sv
// -----------------------------------------------------------------------------
// tb_activ_backprop
// Self-checking bench for activ_backprop: directed vector table, backpressure,
// reset mid-operation and randomized operations against a reference model.
// Honors ACTIV_BP_LEAKY_EN for the ReLU expectations.
// -----------------------------------------------------------------------------
module tb_activ_backprop;

`ifdef ACTIV_BP_LEAKY_EN
    localparam bit LEAKY = 1'b1;
`else
    localparam bit LEAKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        act_sel;
    logic [15:0] x;
    logic [15:0] z;
    logic [15:0] grad_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] grad_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    activ_backprop #(.BITS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act_sel   (act_sel),
        .x         (x),
        .z         (z),
        .grad_in   (grad_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grad_out  (grad_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    // Reference model: straight from the arithmetic definition of the unit.
    function automatic logic [15:0] model(input bit act, input logic [15:0] xv,
                                          input logic [15:0] zv, input logic [15:0] gv);
        int xi, zi, gi, zc, d, p;
        logic [31:0] pv;
        xi = int'($signed(xv));
        zi = int'($signed(zv));
        gi = int'($signed(gv));
        if (!act) begin
            if (xi > 0) p = gi;
            else if (LEAKY) p = gi >>> 4;
            else p = 0;
        end else begin
            zc = (zi < 0) ? 0 : ((zi > 256) ? 256 : zi);
            d  = (zc * (256 - zc)) >>> 8;
            p  = (gi * d) >>> 8;
        end
        pv = p;
        return pv[15:0];
    endfunction

    // One full transaction. stall > 0 holds out_ready low that many cycles
    // after out_valid appears, while also offering a junk input that must be ignored.
    task automatic do_op(input bit act, input logic [15:0] xv, input logic [15:0] zv,
                         input logic [15:0] gv, input int stall,
                         output logic [15:0] res, output int lat);
        int n;
        @(negedge clk);
        act_sel   = act;
        x         = xv;
        z         = zv;
        grad_in   = gv;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                in_valid = 1'b0;
                act_sel  = 1'($urandom);
                x        = 16'($urandom);
                z        = 16'($urandom);
                grad_in  = 16'($urandom);
            end
        end while (!out_valid && n < 20);
        lat = n;
        res = grad_out;
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL op_timeout got out_valid=0 exp out_valid=1");
        end
        for (int k = 0; k < stall; k++) begin
            act_sel  = 1'b0;
            x        = 16'h0123;
            grad_in  = 16'h7777;
            in_valid = 1'b1;
            @(negedge clk);
            chk("stall_hold", {15'd0, out_valid, grad_out}, {15'd0, 1'b1, res});
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
        chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
        chk("busy_after_hs", {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        bit          act;
        logic [15:0] xv;
        logic [15:0] zv;
        logic [15:0] gv;
        logic [15:0] e;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [15:0] res;
        int          lat;
        logic [15:0] exp_v;
        bit          a;
        logic [15:0] xr, zr, gr;

        vecs[0]  = '{1'b0, 16'h0180, 16'h0000, 16'h0200, 16'h0200, 1};
        vecs[1]  = '{1'b0, 16'hFF00, 16'h0000, 16'h0200, LEAKY ? 16'h0020 : 16'h0000, 1};
        vecs[2]  = '{1'b0, 16'h0000, 16'h0000, 16'h0200, LEAKY ? 16'h0020 : 16'h0000, 1};
        vecs[3]  = '{1'b0, 16'h0001, 16'h0000, 16'h8000, 16'h8000, 1};
        vecs[4]  = '{1'b1, 16'h0000, 16'h0080, 16'h0100, 16'h0040, 3};
        vecs[5]  = '{1'b1, 16'h0000, 16'h0080, 16'hFF00, 16'hFFC0, 3};
        vecs[6]  = '{1'b1, 16'h0000, 16'h0180, 16'h0100, 16'h0000, 3};
        vecs[7]  = '{1'b1, 16'h0000, 16'hFFF0, 16'h0100, 16'h0000, 3};
        vecs[8]  = '{1'b1, 16'h0000, 16'h0100, 16'h7FFF, 16'h0000, 3};
        vecs[9]  = '{1'b1, 16'h0000, 16'h0040, 16'h0100, 16'h0030, 3};
        vecs[10] = '{1'b0, 16'h7FFF, 16'h0000, 16'hFFFF, 16'hFFFF, 1};
        vecs[11] = '{1'b0, 16'h8000, 16'h0000, 16'hFFF0, LEAKY ? 16'hFFFF : 16'h0000, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        act_sel   = 1'b0;
        x         = '0;
        z         = '0;
        grad_in   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_grad_out", {16'd0, grad_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].act, vecs[i].xv, vecs[i].zv, vecs[i].gv, 0, res, lat);
            chk($sformatf("vec%0d_grad", i), {16'd0, res}, {16'd0, vecs[i].e});
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // Backpressure: 5 stalled cycles in DONE with a competing input.
        do_op(1'b1, 16'h0000, 16'h0080, 16'h0100, 5, res, lat);
        chk("bp_grad", {16'd0, res}, 32'h0040);
        chk("bp_lat", lat, 3);
        repeat (3) begin
            @(negedge clk);
            chk("bp_no_ghost", {31'd0, out_valid}, 32'd0);
        end

        // Reset during MUL1.
        @(negedge clk);
        act_sel  = 1'b1;
        z        = 16'h0080;
        grad_in  = 16'h0100;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mul1_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstm_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstm_grad_out", {16'd0, grad_out}, 32'd0);
        chk("rstm_busy", {31'd0, busy}, 32'd0);
        chk("rstm_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rstm_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // Reset in DONE with a pending result.
        @(negedge clk);
        act_sel   = 1'b0;
        x         = 16'h0100;
        grad_in   = 16'h1234;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("done_pending", {15'd0, out_valid, grad_out}, {15'd0, 1'b1, 16'h1234});
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstd_out", {15'd0, out_valid, grad_out}, 32'd0);
        chk("rstd_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rstd_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 300; i++) begin
            a  = 1'($urandom);
            xr = 16'($urandom);
            gr = 16'($urandom);
            if ($urandom_range(0, 3) != 0) zr = 16'($urandom_range(0, 319)) - 16'd32;
            else zr = 16'($urandom);
            exp_v = model(a, xr, zr, gr);
            do_op(a, xr, zr, gr, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0, res, lat);
            chk($sformatf("rnd%0d_grad", i), {16'd0, res}, {16'd0, exp_v});
            chk($sformatf("rnd%0d_lat", i), lat, a ? 3 : 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_activ_backprop
